fb_rect_fill: RTL and testbench

Rectangle-fill engine that writes solid-colour pixels into the 400x240 16-bit frame buffer scanned out by the LCD controller. It sits directly upstream of the buffer RAM write port, turning one command (x, y, width, height, colour) into a stream of single-pixel writes. It uses incremental row and column addressing, with no per-pixel multiply.

---
 rtl/fb_pkg.sv | 24 ++
 rtl/fb_rect_addr_gen.sv | 61 ++++++
 rtl/fb_rect_fill.sv | 123 ++++++++++++
 tb/tb_fb_rect_fill.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: geometry, word widths, fill-engine states
// and the y*H_RES shift-add used by both the fill engine and the LCD scan side.
package fb_pkg;

  localparam int H_RES  = 400;
  localparam int V_RES  = 240;
  localparam int ADDR_W = 17;
  localparam int PIX_W  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    FILL  = 2'd2,
    DONE  = 2'd3
  } fb_state_e;

  // 400 = 256 + 128 + 16, so a line's base address needs no multiplier
  function automatic logic [ADDR_W-1:0] row_base_of(input logic [7:0] y);
    logic [ADDR_W-1:0] yw;
    yw = {{(ADDR_W-8){1'b0}}, y};
    return (yw << 8) + (yw << 7) + (yw << 4);
  endfunction

endpackage

// File: rtl/fb_rect_addr_gen.sv
// Column/row walker for the rectangle fill: row_base accumulator plus column,
// frozen whenever advance is low, with a flag marking the final pixel.
module fb_rect_addr_gen #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              load,
  input  logic              advance,
  input  logic [8:0]        x_start,
  input  logic [8:0]        col_last,
  input  logic [7:0]        y_start,
  input  logic [7:0]        row_last,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);
  import fb_pkg::*;

  logic [8:0]        col;
  logic [8:0]        col_first;
  logic [8:0]        col_end;
  logic [7:0]        row;
  logic [7:0]        row_end;
  logic [ADDR_W-1:0] row_base;
  logic              end_col;
  logic              end_row;

  assign end_col = (col == col_end);
  assign end_row = (row == row_end);
  assign last    = end_col && end_row;
  assign addr    = row_base + ADDR_W'(col);

  // Row advance adds one line to row_base instead of recomputing y*H_RES
  always_ff @(posedge clk) begin
    if (!rst_) begin
      col       <= '0;
      col_first <= '0;
      col_end   <= '0;
      row       <= '0;
      row_end   <= '0;
      row_base  <= '0;
    end else if (load) begin
      col       <= x_start;
      col_first <= x_start;
      col_end   <= col_last;
      row       <= y_start;
      row_end   <= row_last;
      row_base  <= row_base_of(y_start);
    end else if (advance) begin
      if (!end_col) begin
        col <= col + 9'd1;
      end else if (!end_row) begin
        col      <= col_first;
        row      <= row + 8'd1;
        row_base <= row_base + ADDR_W'(H_RES);
      end
    end
  end

endmodule

// File: rtl/fb_rect_fill.sv
// Rectangle-fill engine: one (x, y, w, h, colour) command becomes a stream of
// single-pixel frame-buffer writes. Define FB_RECT_CLIP_EN to clip instead of reject.
module fb_rect_fill #(
  parameter int H_RES  = fb_pkg::H_RES,
  parameter int V_RES  = fb_pkg::V_RES,
  parameter int ADDR_W = fb_pkg::ADDR_W,
  parameter int PIX_W  = fb_pkg::PIX_W
) (
  input  logic              clk,
  input  logic              rst_,
  input  logic              iCMD_VALID,
  output logic              oCMD_READY,
  input  logic [8:0]        iX,
  input  logic [7:0]        iY,
  input  logic [8:0]        iW,
  input  logic [7:0]        iH,
  input  logic [PIX_W-1:0]  iCOLOR,
  input  logic              iSTALL,
  output logic              oWE,
  output logic [ADDR_W-1:0] oADDR,
  output logic [PIX_W-1:0]  oWDATA,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oERR
);
  import fb_pkg::*;

  fb_state_e        state, state_nxt;
  logic [8:0]       x_q;
  logic [7:0]       y_q;
  logic [8:0]       w_q;
  logic [7:0]       h_q;
  logic [PIX_W-1:0] color_q;
  logic             err_q;

  logic [9:0] x_ext, y_ext, w_ext, h_ext, w_c, h_c;
  logic       x_out, y_out, setup_err, setup_zero;
  logic       advance, last;

  assign x_ext = {1'b0, x_q};
  assign y_ext = {2'b00, y_q};
  assign w_ext = {1'b0, w_q};
  assign h_ext = {2'b00, h_q};
  assign x_out = (x_ext >= 10'(H_RES));
  assign y_out = (y_ext >= 10'(V_RES));

`ifdef FB_RECT_CLIP_EN
  logic [9:0] w_room, h_room;
  assign w_room    = x_out ? 10'd0 : 10'(H_RES) - x_ext;
  assign h_room    = y_out ? 10'd0 : 10'(V_RES) - y_ext;
  assign w_c       = (w_ext > w_room) ? w_room : w_ext;
  assign h_c       = (h_ext > h_room) ? h_room : h_ext;
  assign setup_err = 1'b0;
`else
  assign w_c       = w_ext;
  assign h_c       = h_ext;
  assign setup_err = x_out || y_out ||
                     ((x_ext + w_ext) > 10'(H_RES)) ||
                     ((y_ext + h_ext) > 10'(V_RES));
`endif

  assign setup_zero = (w_c == 10'd0) || (h_c == 10'd0) || setup_err;
  assign advance    = (state == FILL) && !iSTALL;

  fb_rect_addr_gen #(
    .H_RES  (H_RES),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk      (clk),
    .rst_     (rst_),
    .load     (state == SETUP),
    .advance  (advance),
    .x_start  (x_q),
    .col_last (9'(x_ext + w_c - 10'd1)),
    .y_start  (y_q),
    .row_last (8'(y_ext + h_c - 10'd1)),
    .addr     (oADDR),
    .last     (last)
  );

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state   <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      w_q     <= '0;
      h_q     <= '0;
      color_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && iCMD_VALID) begin
        x_q     <= iX;
        y_q     <= iY;
        w_q     <= iW;
        h_q     <= iH;
        color_q <= iCOLOR;
      end
      if (state == SETUP) begin
        err_q <= setup_err;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (iCMD_VALID) state_nxt = SETUP;
      SETUP:   state_nxt = setup_zero ? DONE : FILL;
      FILL:    if (advance && last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign oCMD_READY = (state == IDLE);
  assign oBUSY      = (state == SETUP) || (state == FILL);
  assign oWE        = advance;
  assign oWDATA     = color_q;
  assign oDONE      = (state == DONE);
  assign oERR       = (state == DONE) && err_q;

endmodule

// File: tb/tb_fb_rect_fill.sv
// Directed bench for fb_rect_fill: reset, plain fill, stalls, out-of-frame
// commands (expectations follow FB_RECT_CLIP_EN), zero area and mid-fill reset.
module tb_fb_rect_fill;

  logic        clk = 1'b0;
  logic        rst_;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [8:0]  w;
  logic [7:0]  h;
  logic [15:0] color;
  logic        stall;
  logic        we;
  logic [16:0] addr;
  logic [15:0] wdata;
  logic        busy;
  logic        done;
  logic        err;

  int tests = 0;
  int fails = 0;

  fb_rect_fill dut (
    .clk        (clk),
    .rst_       (rst_),
    .iCMD_VALID (cmd_valid),
    .oCMD_READY (cmd_ready),
    .iX         (x),
    .iY         (y),
    .iW         (w),
    .iH         (h),
    .iCOLOR     (color),
    .iSTALL     (stall),
    .oWE        (we),
    .oADDR      (addr),
    .oWDATA     (wdata),
    .oBUSY      (busy),
    .oDONE      (done),
    .oERR       (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [8:0] cx, input logic [7:0] cy,
                               input logic [8:0] cw, input logic [7:0] ch, input logic [15:0] cc);
    cmd_valid = v;
    x         = cx;
    y         = cy;
    w         = cw;
    h         = ch;
    color     = cc;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    logic [16:0] addr_exp [8];
    logic        we_exp   [8];
    logic        stall_seq[8];
    int          done_seen;

    rst_  = 1'b0;
    stall = 1'b0;
    applyStimulus(1'b1, 9'd10, 8'd2, 9'd3, 8'd2, 16'hF800);

    // reset held with a command offered: nothing may be accepted
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_ready", cmd_ready, 1);
      checkOutput("rst_we", we, 0);
      checkOutput("rst_busy", busy, 0);
    end
    checkOutput("rst_addr", addr, 0);
    checkOutput("rst_wdata", wdata, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_err", err, 0);
    applyStimulus(1'b0, 9'd10, 8'd2, 9'd3, 8'd2, 16'hF800);
    rst_ = 1'b1;
    tick();
    checkOutput("post_rst_busy", busy, 0);
    checkOutput("post_rst_ready", cmd_ready, 1);

    // plain 3x2 fill at (10,2)
    addr_exp = '{17'd810, 17'd811, 17'd812, 17'd1210, 17'd1211, 17'd1212, 17'd0, 17'd0};
    applyStimulus(1'b1, 9'd10, 8'd2, 9'd3, 8'd2, 16'hF800);
    checkOutput("a_ready_T", cmd_ready, 1);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    checkOutput("a_setup_busy", busy, 1);
    checkOutput("a_setup_we", we, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("a_we", we, 1);
      checkOutput("a_addr", addr, addr_exp[i]);
      checkOutput("a_wdata", wdata, 16'hF800);
      checkOutput("a_done_early", done, 0);
    end
    tick();
    checkOutput("a_done", done, 1);
    checkOutput("a_done_we", we, 0);
    checkOutput("a_err", err, 0);
    checkOutput("a_done_ready", cmd_ready, 0);
    tick();
    checkOutput("a_ready_back", cmd_ready, 1);
    checkOutput("a_done_clear", done, 0);

    // same command with stalls at T+3 and T+4
    stall_seq = '{0, 1, 1, 0, 0, 0, 0, 0};
    we_exp    = '{1, 0, 0, 1, 1, 1, 1, 1};
    addr_exp  = '{17'd810, 17'd811, 17'd811, 17'd811, 17'd812, 17'd1210, 17'd1211, 17'd1212};
    applyStimulus(1'b1, 9'd10, 8'd2, 9'd3, 8'd2, 16'h07E0);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      tick();
      stall = stall_seq[i];
      #1;
      checkOutput("b_we", we, we_exp[i]);
      checkOutput("b_addr", addr, addr_exp[i]);
      checkOutput("b_done_early", done, 0);
    end
    tick();
    stall = 1'b0;
    #1;
    checkOutput("b_done", done, 1);
    checkOutput("b_wdata", wdata, 16'h07E0);
    tick();

    // rectangle hanging off the bottom-right corner
    applyStimulus(1'b1, 9'd398, 8'd239, 9'd5, 8'd3, 16'h001F);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    tick();
`ifdef FB_RECT_CLIP_EN
    checkOutput("c_we0", we, 1);
    checkOutput("c_addr0", addr, 95998);
    tick();
    checkOutput("c_we1", we, 1);
    checkOutput("c_addr1", addr, 95999);
    tick();
    checkOutput("c_done", done, 1);
    checkOutput("c_err", err, 0);
    checkOutput("c_we_done", we, 0);
`else
    checkOutput("c_done", done, 1);
    checkOutput("c_err", err, 1);
    checkOutput("c_we", we, 0);
`endif
    tick();
    checkOutput("c_ready_back", cmd_ready, 1);
    checkOutput("c_err_clear", err, 0);

    // zero-width command, second command offered while DONE
    applyStimulus(1'b1, 9'd5, 8'd5, 9'd0, 8'd5, 16'hFFFF);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    checkOutput("d_setup_we", we, 0);
    tick();
    applyStimulus(1'b1, 9'd0, 8'd0, 9'd1, 8'd1, 16'h1234);
    checkOutput("d_done", done, 1);
    checkOutput("d_err", err, 0);
    checkOutput("d_we", we, 0);
    checkOutput("d_ready_at_done", cmd_ready, 0);
    tick();
    checkOutput("d2_ready", cmd_ready, 1);
    checkOutput("d2_not_busy", busy, 0);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    checkOutput("d2_setup_busy", busy, 1);
    tick();
    checkOutput("d2_we", we, 1);
    checkOutput("d2_addr", addr, 0);
    checkOutput("d2_wdata", wdata, 16'h1234);
    tick();
    checkOutput("d2_done", done, 1);
    tick();

    // 10x10 fill at (0,10), reset during the fourth write
    applyStimulus(1'b1, 9'd0, 8'd10, 9'd10, 8'd10, 16'hAAAA);
    tick();
    applyStimulus(1'b0, 9'd0, 8'd0, 9'd0, 8'd0, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("e_we", we, 1);
      checkOutput("e_addr", addr, 4000 + i);
    end
    rst_ = 1'b0;
    tick();
    checkOutput("e_rst_we", we, 0);
    checkOutput("e_rst_ready", cmd_ready, 1);
    checkOutput("e_rst_busy", busy, 0);
    checkOutput("e_rst_done", done, 0);
    rst_ = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 110; i++) begin
      tick();
      if (done || we) done_seen++;
    end
    checkOutput("e_no_done_or_write", done_seen, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
